fsm_state_tracker: RTL

//   Downstream observer of the 4-bit FSM state output (fsm_16 state_out).

---
 rtl/fsm_state_tracker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fsm_state_tracker.sv
// ----------------------------------------------------------------------------
// fsm_state_tracker
//   Watches the 4-bit state output of an upstream FSM. It samples the state on
//   every clock and notices each change of state. For every change it queues
//   one event {prev_state, next_state, dwell} in a small FIFO. A logger or
//   checker drains the FIFO. The block also keeps a transition counter, a
//   saturating drop counter and a sticky overflow flag.
//
// Ports
//   clk         in   clock; all state updates on the rising edge
//   reset       in   asynchronous, active-low reset
//   state_in    in   [3:0] observed FSM state
//   clr_ovf     in   synchronous clear of overflow and drop_cnt
//   evt_ready   in   consumer accepts the head event
//   evt_valid   out  FIFO holds at least one event
//   evt_prev    out  [3:0] head event: state that was left
//   evt_next    out  [3:0] head event: state that was entered
//   evt_dwell   out  [DWELL_W-1:0] head event: cycles spent in evt_prev
//   fifo_count  out  [$clog2(DEPTH):0] occupied entries, 0..DEPTH
//   trans_cnt   out  [CNT_W-1:0] transitions since reset, dropped ones included
//   drop_cnt    out  [7:0] events lost on a full FIFO, saturates at 255
//   overflow    out  sticky flag, set when at least one event is dropped
//
// Handshake: the head event moves on a rising edge where evt_valid and
//   evt_ready are both high. While evt_valid is high and evt_ready is low, the
//   head fields hold steady. evt_ready has no effect when the FIFO is empty.
// ----------------------------------------------------------------------------
module fsm_state_tracker #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               state_in,
    input  logic                     clr_ovf,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [3:0]               evt_prev,
    output logic [3:0]               evt_next,
    output logic [DWELL_W-1:0]       evt_dwell,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         trans_cnt,
    output logic [7:0]               drop_cnt,
    output logic                     overflow
);

    localparam int                  AW        = $clog2(DEPTH);
    localparam logic [AW:0]         FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [DWELL_W-1:0]  DWELL_MAX = '1;

    // Tracker state
    logic                armed;
    logic [3:0]          prev_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    // Event storage. The head outputs are gated by evt_valid, so this array
    // needs no reset.
    logic [3:0]          prev_mem  [DEPTH];
    logic [3:0]          next_mem  [DEPTH];
    logic [DWELL_W-1:0]  dwell_mem [DEPTH];

    logic transition;
    logic fifo_full;
    logic pop;
    logic push_ok;
    logic drop;

    assign transition = armed && (state_in != prev_q);
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign evt_valid  = (fifo_count != '0);
    assign pop        = evt_valid && evt_ready;
    // A full FIFO can still take a push when the head leaves on the same edge.
    assign push_ok    = transition && (!fifo_full || pop);
    assign drop       = transition && fifo_full && !pop;

    assign evt_prev  = evt_valid ? prev_mem[rd_ptr]  : '0;
    assign evt_next  = evt_valid ? next_mem[rd_ptr]  : '0;
    assign evt_dwell = evt_valid ? dwell_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            prev_mem[wr_ptr]  <= prev_q;
            next_mem[wr_ptr]  <= state_in;
            dwell_mem[wr_ptr] <= dwell_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed      <= 1'b0;
            prev_q     <= '0;
            dwell_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            trans_cnt  <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            // The first edge after reset only captures the current state. No
            // event comes from it, so no event spans a reset.
            if (!armed) begin
                armed   <= 1'b1;
                prev_q  <= state_in;
                dwell_q <= DWELL_W'(1);
            end else if (transition) begin
                prev_q    <= state_in;
                dwell_q   <= DWELL_W'(1);
                trans_cnt <= trans_cnt + 1'b1;
            end else if (dwell_q != DWELL_MAX) begin
                dwell_q <= dwell_q + 1'b1;
            end

            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;

            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            // A drop on the same edge as clr_ovf wins. The clear is applied
            // first and then the new drop is counted.
            if (drop) begin
                overflow <= 1'b1;
                if (clr_ovf)                drop_cnt <= 8'd1;
                else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule
